// File: rtl/fiat_25519_mul_pkg.sv
// Shared types and constants for the fiat_25519 multiplier scheduler and its arbiter.
package fiat_25519_mul_pkg;

    localparam int DEF_A_W = 14;
    localparam int DEF_B_W = 12;
    localparam int DEF_P_W = 26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

    // Requester tag width; a single requester still gets one tag bit.
    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fiat_25519_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above the pointer, with wrap.
module fiat_25519_rr_arbiter
    import fiat_25519_mul_pkg::*;
#(
    parameter int N  = 4,
    parameter int TW = tag_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [TW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [TW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = TW'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/fiat_25519_mul_sched.sv
// Round-robin sharing of one external signed multiplier between NREQ requesters, with flush/drain.
// Optional per-requester grant and conflict counters when FIAT_MUL_SCHED_STATS_EN is defined.
module fiat_25519_mul_sched
    import fiat_25519_mul_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int A_W     = DEF_A_W,
    parameter int B_W     = DEF_B_W,
    parameter int P_W     = DEF_P_W,
    parameter int MUL_LAT = 0
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*A_W-1:0] req_a,
    input  logic [NREQ*B_W-1:0] req_b,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [P_W-1:0]      rsp_data,
    output logic [A_W-1:0]      mul_din0,
    output logic [B_W-1:0]      mul_din1,
    input  logic [P_W-1:0]      mul_dout,
    input  logic                flush,
    output logic                flush_done,
    output logic                busy,
    output sched_state_e        dbg_state_o
`ifdef FIAT_MUL_SCHED_STATS_EN
    ,
    output logic [NREQ*16-1:0]  grant_cnt,
    output logic [15:0]         conflict_cnt
`endif
);

    localparam int TAG_W = tag_w(NREQ);
    localparam int DEPTH = MUL_LAT + 1;

    sched_state_e      state_q, state_d;
    logic [TAG_W-1:0]  ptr_q, ptr_d;
    logic [A_W-1:0]    din0_q;
    logic [B_W-1:0]    din1_q;
    logic [DEPTH-1:0]  vld_q;
    logic [TAG_W-1:0]  tag_q [DEPTH];
    logic [NREQ-1:0]   rsp_valid_q;
    logic [P_W-1:0]    rsp_data_q;
    logic              flush_done_q;

    logic [NREQ-1:0]   arb_gnt;
    logic [TAG_W-1:0]  arb_idx;
    logic              arb_any;
    logic              grant_en;
    logic              xfer;
    logic              pipe_busy;

    fiat_25519_rr_arbiter #(.N(NREQ), .TW(TAG_W)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Flush takes priority over any pending request in the same cycle.
    assign grant_en  = !ap_rst && !flush && (state_q != ST_DRAIN);
    assign req_ready = grant_en ? arb_gnt : '0;
    assign xfer      = grant_en && arb_any;
    assign pipe_busy = |vld_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (flush) state_d = ST_DRAIN;
                      else if (xfer) state_d = ST_RUN;
            ST_RUN:   if (flush) state_d = ST_DRAIN;
                      else if (!pipe_busy && !xfer) state_d = ST_IDLE;
            ST_DRAIN: if (!flush) state_d = pipe_busy ? ST_RUN : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            din0_q       <= '0;
            din1_q       <= '0;
            vld_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            flush_done_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) tag_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            flush_done_q <= flush && (state_q == ST_DRAIN) && !pipe_busy;
            if (xfer) begin
                din0_q <= req_a[int'(arb_idx)*A_W +: A_W];
                din1_q <= req_b[int'(arb_idx)*B_W +: B_W];
            end
            // Tag pipe tracks the multiplier latency so results return to their owner.
            vld_q[0] <= xfer;
            tag_q[0] <= arb_idx;
            for (int k = 1; k < DEPTH; k++) begin
                vld_q[k] <= vld_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
            rsp_valid_q <= vld_q[MUL_LAT] ? ({{(NREQ-1){1'b0}}, 1'b1} << tag_q[MUL_LAT]) : '0;
            if (vld_q[MUL_LAT]) rsp_data_q <= mul_dout;
        end
    end

    assign mul_din0    = din0_q;
    assign mul_din1    = din1_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign flush_done  = flush_done_q && flush;
    assign busy        = (state_q != ST_IDLE) || pipe_busy;
    assign dbg_state_o = state_q;

`ifdef FIAT_MUL_SCHED_STATS_EN
    logic [15:0] gcnt_q [NREQ];
    logic [15:0] ccnt_q;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int k = 0; k < NREQ; k++) gcnt_q[k] <= '0;
            ccnt_q <= '0;
        end else begin
            if (xfer && gcnt_q[arb_idx] != 16'hFFFF) gcnt_q[arb_idx] <= gcnt_q[arb_idx] + 1'b1;
            if ($countones(req_valid) > 1 && ccnt_q != 16'hFFFF) ccnt_q <= ccnt_q + 1'b1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_gcnt
        assign grant_cnt[g*16 +: 16] = gcnt_q[g];
    end
    assign conflict_cnt = ccnt_q;
`endif

endmodule
